// File: rtl/trig_gen_pkg.sv
// trig_gen shared constants: control-word field positions,
// cyclic base period and holdoff sizing.
package trig_gen_pkg;

  localparam int TR_EN   = 15;
  localparam int TR_SELF = 14;
  localparam int TR_EXT  = 13;
  localparam int TR_CYC  = 12;

  localparam int P_HI = 11;
  localparam int P_LO = 8;
  localparam int H_HI = 7;
  localparam int H_LO = 4;
  localparam int RSVD = 3;
  localparam int M_HI = 2;
  localparam int M_LO = 0;

  localparam int CYC_BASE_DEF = 1024;
  localparam int HOLD_MULT    = 4;
  localparam int HOLD_W       = 7;

  function automatic logic [HOLD_W-1:0] hold_len(
    input logic [H_HI-H_LO:0] h
  );
    return HOLD_W'((int'(h) + 1) * HOLD_MULT);
  endfunction

endpackage

// File: rtl/trig_gen_if.sv
// trig_gen control/trigger bundle; master drives config and
// trigger sources, slave returns the trigger pulses.
interface trig_gen_if #(
  parameter int NCH = 3
);

  logic           trigger_stun;
  logic [15:0]    trigger_reg;
  logic [NCH-1:0] overth;
  logic           trig_in;
  logic           trig_out;
  logic           cyctrig_pls;

  modport master (
    output trigger_stun,
    output trigger_reg,
    output overth,
    output trig_in,
    input  trig_out,
    input  cyctrig_pls
  );

  modport slave (
    input  trigger_stun,
    input  trigger_reg,
    input  overth,
    input  trig_in,
    output trig_out,
    output cyctrig_pls
  );

endinterface

// File: rtl/trig_sync_edge.sv
// Two-flop synchroniser for an asynchronous level followed by
// an edge register; pulse marks the synchronised rising edge.
module trig_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/trig_gen.sv
// Trigger generator: merges self, external and cyclic sources
// into a single registered trig_out pulse with stun and holdoff.
module trig_gen
  import trig_gen_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int CYC_BASE = CYC_BASE_DEF,
  parameter int CNT_W    = 26
) (
  input  logic     init_clk,
  input  logic     reset_i,
  trig_gen_if.slave bus
);

  logic [15:0]      cfg;
  logic [P_HI-P_LO:0] per_code;
  logic [H_HI-H_LO:0] hold_code;
  logic [NCH-1:0]   mask;
  logic             unused_rsvd;

  assign cfg         = bus.trigger_reg;
  assign per_code    = cfg[P_HI:P_LO];
  assign hold_code   = cfg[H_HI:H_LO];
  assign mask        = NCH'(cfg[M_HI:M_LO]);
  assign unused_rsvd = cfg[RSVD];

  logic [NCH-1:0]    overth_d;
  logic              ext_pls;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_last;
  logic [P_HI-P_LO:0] per_d;
  logic [HOLD_W-1:0] hcnt;

  logic cyc_run;
  logic per_chg;
  logic cyc_hit;
  logic self_hit;
  logic ext_hit;
  logic hold_act;
  logic hit;

  trig_sync_edge u_ext (
    .clk   (init_clk),
    .rst_n (reset_i),
    .din   (bus.trig_in),
    .pulse (ext_pls)
  );

  assign cnt_last = (CNT_W'(CYC_BASE) << per_code)
                  - CNT_W'(1);
  assign cyc_run  = cfg[TR_CYC];
  assign per_chg  = per_code != per_d;
  assign cyc_hit  = cyc_run & ~per_chg
                  & (cnt == cnt_last);

  assign self_hit = cfg[TR_SELF]
                  & |(bus.overth & ~overth_d & mask);
  assign ext_hit  = cfg[TR_EXT] & ext_pls;
  assign hold_act = hcnt != '0;

  assign hit = cfg[TR_EN] & ~bus.trigger_stun & ~hold_act
             & (self_hit | ext_hit | cyc_hit);

  // Cyclic counter runs regardless of enable/stun so the tick
  // stays periodic; a period change restarts it from zero.
  always_ff @(posedge init_clk or negedge reset_i) begin
    if (!reset_i) begin
      cnt             <= '0;
      per_d           <= '0;
      bus.cyctrig_pls <= 1'b0;
    end else begin
      per_d           <= per_code;
      bus.cyctrig_pls <= cyc_hit;
      if (!cyc_run || per_chg || cyc_hit) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Holdoff is armed only by an accepted hit, so it also masks
  // the pulse cycle itself and keeps trig_out single-cycle.
  always_ff @(posedge init_clk or negedge reset_i) begin
    if (!reset_i) begin
      overth_d     <= '0;
      hcnt         <= '0;
      bus.trig_out <= 1'b0;
    end else begin
      overth_d     <= bus.overth;
      bus.trig_out <= hit;
      if (hit) begin
        hcnt <= hold_len(hold_code);
      end else if (hold_act) begin
        hcnt <= hcnt - HOLD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_trig_gen.sv
// Directed bench for trig_gen with a cycle-level behavioural
// model and literal pulse-count / timing expectations.
module tb_trig_gen;

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #4 clk = ~clk;

  trig_gen_if #(.NCH(3)) ifc ();

  trig_gen #(.NCH(3), .CYC_BASE(1024), .CNT_W(26)) dut (
    .init_clk (clk),
    .reset_i  (reset_i),
    .bus      (ifc)
  );

  // Behavioural model: edge index arithmetic per source rule.
  longint e, e0, blk;
  logic [3:0]  prev_p;
  logic [2:0]  prev_ov;
  logic        s1, s2, s3;
  logic        exp_trig = 1'b0;
  logic        exp_cyc = 1'b0;

  always @(posedge clk) begin
    logic [15:0] cfg;
    logic [3:0]  p;
    longint      per;
    logic        tick, self_h, ext_h, hit_m;
    if (!reset_i) begin
      e = 0; e0 = 0; blk = -1;
      prev_p = '0; prev_ov = '0;
      s1 = 0; s2 = 0; s3 = 0;
      exp_trig = 0; exp_cyc = 0;
    end else begin
      e++;
      cfg = ifc.trigger_reg;
      p = cfg[11:8];
      per = 64'd1024 << p;
      if (!cfg[12] || p != prev_p) begin
        e0 = e;
        tick = 0;
      end else begin
        tick = ((e - e0) % per) == 0;
      end
      self_h = cfg[14] &&
        ((ifc.overth & ~prev_ov & cfg[2:0]) != 3'b000);
      ext_h = cfg[13] && s2 && !s3;
      hit_m = cfg[15] && !ifc.trigger_stun && (e > blk)
        && (self_h || ext_h || tick);
      if (hit_m) blk = e + 4 * (longint'(cfg[7:4]) + 1);
      exp_trig = hit_m;
      exp_cyc = tick;
      prev_p = p;
      prev_ov = ifc.overth;
      s3 = s2; s2 = s1; s1 = ifc.trig_in;
    end
  end

  always @(negedge clk) begin
    logic et, ec;
    et = reset_i ? exp_trig : 1'b0;
    ec = reset_i ? exp_cyc : 1'b0;
    checks++;
    if (ifc.trig_out !== et) begin
      failures++;
      $display("FAIL model_trig t=%0t got %b want %b",
               $time, ifc.trig_out, et);
    end
    checks++;
    if (ifc.cyctrig_pls !== ec) begin
      failures++;
      $display("FAIL model_cyc t=%0t got %b want %b",
               $time, ifc.cyctrig_pls, ec);
    end
  end

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic win(input int n, output int t, output int c);
    t = 0; c = 0;
    repeat (n) begin
      @(negedge clk);
      if (ifc.trig_out) t++;
      if (ifc.cyctrig_pls) c++;
    end
  endtask

  task automatic pair(input int gap, output int n);
    n = 0;
    ifc.overth = 3'b001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.trig_out) n++;
      ifc.overth = (i + 1 == gap) ? 3'b001 : 3'b000;
    end
  endtask

  initial begin
    int t, c, n;
    bit found;
    ifc.trigger_stun = 0;
    ifc.trigger_reg = 16'h0000;
    ifc.overth = 3'b000;
    ifc.trig_in = 0;
    cyc(5);
    chk("reset_trig", ifc.trig_out, 0);
    chk("reset_cyc", ifc.cyctrig_pls, 0);
    reset_i = 1;
    ifc.trigger_reg = 16'hE005;
    cyc(3);

    ifc.overth = 3'b001;
    @(negedge clk);
    chk("self_fire", ifc.trig_out, 1);
    @(negedge clk);
    chk("self_single", ifc.trig_out, 0);
    ifc.overth = 3'b011;
    win(4, t, c);
    chk("self_masked", t, 0);
    ifc.overth = 3'b000;
    cyc(6);

    ifc.trig_in = 1;
    @(negedge clk);
    chk("ext_k0", ifc.trig_out, 0);
    @(negedge clk);
    chk("ext_k1", ifc.trig_out, 0);
    @(negedge clk);
    chk("ext_k2", ifc.trig_out, 1);
    win(22, t, c);
    chk("ext_held", t, 0);
    ifc.trig_in = 0;
    cyc(6);

    ifc.trigger_stun = 1;
    ifc.overth = 3'b001;
    win(4, t, c);
    chk("stun_drop", t, 0);
    ifc.overth = 3'b000;
    cyc(2);
    ifc.trigger_stun = 0;
    ifc.overth = 3'b100;
    win(3, t, c);
    chk("stun_release", t, 1);
    ifc.overth = 3'b000;
    cyc(8);

    ifc.trigger_reg = 16'hE015;
    cyc(2);
    pair(5, n);
    chk("hold_gap5", n, 1);
    cyc(20);
    pair(9, n);
    chk("hold_gap9", n, 2);
    cyc(20);

    ifc.trigger_reg = 16'h9000;
    win(3074, t, c);
    chk("cyc_trig", t, 3);
    chk("cyc_pls", c, 3);
    ifc.trigger_reg = 16'h1000;
    win(2050, t, c);
    chk("cyc_noen_trig", t, 0);
    chk("cyc_noen_pls", c, 2);

    ifc.trigger_reg = 16'h9000;
    found = 0;
    for (int i = 0; i < 2100 && !found; i++) begin
      @(negedge clk);
      if (ifc.cyctrig_pls) found = 1;
    end
    chk("cyc_tick_seen", found, 1);
    chk("cyc_tick_trig", ifc.trig_out, 1);
    #1 reset_i = 0;
    #1;
    chk("rst_async_trig", ifc.trig_out, 0);
    chk("rst_async_cyc", ifc.cyctrig_pls, 0);
    cyc(3);
    reset_i = 1;
    win(1023, t, c);
    chk("rst_early_pls", c, 0);
    win(2, t, c);
    chk("rst_first_pls", c, 1);

    ifc.trigger_reg = 16'h9100;
    win(2047, t, c);
    chk("p1_early_pls", c, 0);
    win(2, t, c);
    chk("p1_first_pls", c, 1);
    chk("p1_first_trig", t, 1);

    cyc(4);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/trig_gen.md
Name: trig_gen

Overview:
- Trigger generator for the DAQ path, clocked by the 125 MHz init_clk.
- Merges three trigger sources into one trigger pulse, trig_out:
  - per-channel over-threshold flags (self trigger);
  - an asynchronous external trigger input;
  - an internal cyclic (periodic) trigger.
- All configuration comes from a single 16-bit control word, trigger_reg. A stun input vetoes triggers while downstream is busy.

Parameters:
- NCH, 3, number of over-threshold channels (width of overth and of the channel mask).
- CYC_BASE, 1024, cyclic period base in clock cycles.
- CNT_W, 26, cyclic counter width; must hold CYC_BASE<<15.

Ports:
- init_clk  in  1  system clock, 125 MHz; all logic is on the rising edge.
- reset_i  in  1  asynchronous, active-low reset. While low, all state and outputs are cleared.
- trigger_stun  in  1  synchronous veto; while high, no trig_out is produced.
- trigger_reg  in  16  control word, quasi-static, used live:
  - [15] global trigger enable
  - [14] self-trigger enable
  - [13] external-trigger enable
  - [12] cyclic-trigger enable
  - [11:8] cyclic period code P
  - [7:4] holdoff code H
  - [3] reserved, ignored
  - [2:0] overth channel mask
- overth  in  NCH  over-threshold flags, synchronous to init_clk.
- trig_in  in  1  external trigger, asynchronous level.
- trig_out  out  1  one-cycle trigger pulse, registered.
- cyctrig_pls  out  1  one-cycle cyclic tick, registered.

Behaviour:
- Reset (reset_i=0): trig_out=0, cyctrig_pls=0; counters, synchronisers and edge registers cleared.
- Self trigger:
  - self_hit = |(overth & ~overth_d & mask), where overth_d is overth registered once. Only rising edges count.
  - An overth bit rising before edge k drives trig_out high for the cycle after edge k.
  - Gated by [14].
- External trigger:
  - trig_in passes a 2-FF synchroniser plus one edge register; ext_hit is the rising edge.
  - If trig_in is first sampled high at edge k, trig_out is high after edge k+2.
  - Gated by [13]. A level held high yields exactly one trigger.
- Cyclic trigger:
  - While [12]=1, the counter counts 0 .. (CYC_BASE<<P)-1.
  - At terminal count the counter wraps to 0 and cyctrig_pls goes high for one cycle. This is independent of [15] and of trigger_stun.
  - While [12]=0 the counter is held at 0 and there is no pulse.
  - A change of P restarts the counter at 0.
  - Period range: 1024 cycles (8.192 µs) to 33,554,432 cycles.
- Cyclic-to-trigger path: cyc_hit is the cyclic terminal-count condition, and it contributes to the trigger OR.
- Trigger merge:
  - hit = [15] & ~trigger_stun & ~holdoff_active & (self_hit | ext_hit | cyc_hit).
  - trig_out <= hit: single-cycle pulse. Simultaneous sources produce one pulse only.
- Holdoff:
  - After each trig_out pulse, holdoff_active stays high for 4*(H+1) cycles, starting the cycle after the pulse.
  - Hits during holdoff are dropped, not queued.
- Stun:
  - Hits during stun are dropped and do not start holdoff.
  - Stun does not reset the cyclic counter or the edge registers.
- Disabled source: its edge registers keep updating, so enabling a source while its input is already high does not fire.
- Reset mid-count: all state is cleared immediately; counting resumes from 0 after release.

Decomposition:
- Shared package trig_gen_pkg holds:
  - bit-position constants TR_EN=15, TR_SELF=14, TR_EXT=13, TR_CYC=12;
  - field ranges for P, H and the mask;
  - CYC_BASE and the holdoff multiplier (4).
- One sub-module, trig_sync_edge: 2-FF synchroniser plus rising-edge pulse, instantiated for trig_in.

Test Plan:
- Reset, then trigger_reg=16'hE005, overth 0->3'b001 -> one trig_out pulse one cycle later. overth[1] rising (masked off) -> no pulse.
- trigger_reg=16'hE005, trig_in held high 200 ns -> exactly one trig_out, high after edge k+2; no second pulse while trig_in stays high.
- trigger_reg=16'h9000 (cyclic, P=0) -> cyctrig_pls and trig_out every 1024 cycles. Set bit15=0 -> cyctrig_pls continues, trig_out stops.
- trigger_reg=16'hE005 with trigger_stun=1, overth[0] rising -> no trig_out. Stun released, overth[2] rising -> pulse.
- trigger_reg=16'hE015 (H=1): two overth[0] rising edges 5 cycles apart -> second is dropped. Edges 9 cycles apart -> both fire.
- Cyclic counter mid-count, reset_i pulsed low -> outputs 0 at once; first cyctrig_pls comes 1024 cycles after release.
